// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   Sequential universal shift register: parallel load plus SRL, SRA, SLL,
//   ROR, ROL and serial-in right shift, one bit position per clock, under a
//   start/busy/done handshake.
//
// Parameters
//   WIDTH  data width (>= 2)
//   AMT_W  shift-amount width; amounts up to 2^AMT_W-1, may exceed WIDTH
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   load_val   parallel load value
//   load       parallel load request (IDLE only, beats start)
//   start      command strobe (IDLE only)
//   op         operation code, sampled with start
//   amount     number of 1-bit steps, sampled with start
//   ser_in     fill bit for SIR, sampled every step
//   Q          register contents
//   busy       command in progress
//   done       one-cycle completion pulse
//   shift_out  last bit shifted or rotated out
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             shift_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_SRL = 3'b000,
    OP_SRA = 3'b001,
    OP_SLL = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100,
    OP_SIR = 3'b101
  } op_t;

  state_t           state, state_next;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt;

  logic             accept;     // nonzero command taken this cycle
  logic             zero_cmd;   // zero-amount command: done only
  logic             last_step;  // RUN step that finishes the command

  logic [WIDTH-1:0] q_step;
  logic             so_step;

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    zero_cmd   = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (!load && start) begin
          if (amount == '0) begin
            zero_cmd = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        last_step = (cnt == AMT_W'(1));
        if (last_step) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-bit step for the latched operation; reserved codes hold.
  always_comb begin
    q_step  = Q;
    so_step = shift_out;
    case (op_r)
      OP_SRL: begin q_step = {1'b0, Q[WIDTH-1:1]};        so_step = Q[0];       end
      OP_SRA: begin q_step = {Q[WIDTH-1], Q[WIDTH-1:1]};  so_step = Q[0];       end
      OP_SLL: begin q_step = {Q[WIDTH-2:0], 1'b0};        so_step = Q[WIDTH-1]; end
      OP_ROR: begin q_step = {Q[0], Q[WIDTH-1:1]};        so_step = Q[0];       end
      OP_ROL: begin q_step = {Q[WIDTH-2:0], Q[WIDTH-1]};  so_step = Q[WIDTH-1]; end
      OP_SIR: begin q_step = {ser_in, Q[WIDTH-1:1]};      so_step = Q[0];       end
      default: begin q_step = Q;                          so_step = shift_out;  end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_out <= 1'b0;
      op_r      <= '0;
      cnt       <= '0;
    end else begin
      done <= zero_cmd | last_step;
      busy <= (state_next == RUN);
      if (state == IDLE) begin
        if (load) Q <= load_val;
        if (accept) begin
          op_r <= op;
          cnt  <= amount;
        end
      end else begin
        Q         <= q_step;
        shift_out <= so_step;
        cnt       <= cnt - AMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_val;
  logic       load;
  logic       start;
  logic [2:0] op;
  logic [2:0] amount;
  logic       ser_in;
  logic [7:0] Q;
  logic       busy;
  logic       done;
  logic       shift_out;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  universal_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .reset(reset), .load_val(load_val), .load(load),
    .start(start), .op(op), .amount(amount), .ser_in(ser_in),
    .Q(Q), .busy(busy), .done(done), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
    chk("load_q", Q, v);
  endtask

  // Issue a nonzero command; returns in the done cycle after checking results.
  task automatic run_cmd(input string tag, input logic [2:0] o, input logic [2:0] n,
                         input logic [7:0] exp_q, input logic exp_so);
    start = 1'b1; op = o; amount = n;
    tick();
    start = 1'b0;
    for (int i = 1; i < n; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_nodone"}, done, 1'b0);
      tick();
    end
    chk({tag, "_busylast"}, busy, 1'b1);
    tick();
    chk({tag, "_q"}, Q, exp_q);
    chk({tag, "_so"}, shift_out, exp_so);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; load_val = '0;
    op = '0; amount = '0; ser_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_q", Q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_so", shift_out, 1'b0);

    // Asynchronous reset mid-cycle.
    do_load(8'hA5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_q", Q, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_so", shift_out, 1'b0);
    tick();
    reset = 1'b0;

    // SRA / SRL by 3.
    do_load(8'hB4);
    run_cmd("sra3", 3'b001, 3'd3, 8'hF6, 1'b1);
    tick();
    chk("sra3_pulse", done, 1'b0);
    do_load(8'hB4);
    run_cmd("srl3", 3'b000, 3'd3, 8'h16, 1'b1);
    tick();

    // SLL by 2, ROR by 7.
    do_load(8'hB4);
    run_cmd("sll2", 3'b010, 3'd2, 8'hD0, 1'b0);
    tick();
    do_load(8'h81);
    run_cmd("ror7", 3'b011, 3'd7, 8'h03, 1'b0);
    tick();

    // SIR by 4, then ROL issued in the done cycle.
    do_load(8'h00);
    ser_in = 1'b1;
    run_cmd("sir4", 3'b101, 3'd4, 8'hF0, 1'b0);
    ser_in = 1'b0;
    run_cmd("b2b_rol1", 3'b100, 3'd1, 8'hE1, 1'b1);
    tick();
    chk("b2b_pulse", done, 1'b0);

    // load/start during RUN are ignored.
    do_load(8'hFF);
    start = 1'b1; op = 3'b000; amount = 3'd5;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; load_val = 8'h00; start = 1'b1; op = 3'b010; amount = 3'd1;
    tick();
    load = 1'b0; start = 1'b0;
    tick(); tick();
    chk("ign_busy", busy, 1'b1);
    tick();
    chk("ign_q", Q, 8'h07);
    chk("ign_done", done, 1'b1);
    tick();
    chk("ign_noqueue_busy", busy, 1'b0);
    chk("ign_noqueue_done", done, 1'b0);
    chk("ign_noqueue_q", Q, 8'h07);

    // Abort after two steps of SRL by 5.
    do_load(8'hFF);
    start = 1'b1; op = 3'b000; amount = 3'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("abort_mid_q", Q, 8'h3F);
    reset = 1'b1;
    #1;
    chk("abort_q", Q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", done, 1'b0);
      tick();
    end

    // Zero amount.
    do_load(8'h3C);
    start = 1'b1; op = 3'b000; amount = 3'd0;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_q", Q, 8'h3C);
    tick();
    chk("zero_pulse", done, 1'b0);
    chk("zero_busy2", busy, 1'b0);

    // load beats start in the same cycle.
    load = 1'b1; load_val = 8'h5A; start = 1'b1; op = 3'b000; amount = 3'd3;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ldst_q", Q, 8'h5A);
    chk("ldst_busy", busy, 1'b0);
    tick();
    chk("ldst_busy2", busy, 1'b0);
    chk("ldst_done", done, 1'b0);
    chk("ldst_q2", Q, 8'h5A);

    // Reserved op: holds Q/shift_out but still counts.
    run_cmd("rsv2", 3'b110, 3'd2, 8'h5A, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
